// File: rtl/stepmania_pkg.sv
// Shared types and defaults for the per-lane hit judge: grades, lane FSM
// states, timing windows, point values and a 4-bit saturating adder.
package stepmania_pkg;

    localparam int NUM_LANES        = 4;
    localparam int DEF_PERFECT_WIN  = 4;
    localparam int DEF_GOOD_WIN     = 10;
    localparam int DEF_OK_WIN       = 20;
    localparam int DEF_PTS_PERFECT  = 3;
    localparam int DEF_PTS_GOOD     = 2;
    localparam int DEF_PTS_OK       = 1;
    localparam int DEF_DEBOUNCE_CYC = 50000;
    localparam int COMBO_BONUS_AT   = 50;
    localparam int COMBO_MAX        = 1023;

    typedef enum logic [1:0] {
        G_NONE    = 2'd0,
        G_OK      = 2'd1,
        G_GOOD    = 2'd2,
        G_PERFECT = 2'd3
    } grade_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HELD    = 2'd1,
        S_LOCKOUT = 2'd2
    } lane_state_t;

    function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [2:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {2'b00, b};
        return (s > 5'd15) ? 4'd15 : s[3:0];
    endfunction

endpackage

// File: rtl/hit_judge_lane.sv
// One lane of the hit judge: key synchronizer, press/lockout FSM, timing
// judge and per-frame hit/miss accumulators. Bonus/event ports exist only with HIT_JUDGE_COMBO_EN.
module lane_judge
    import stepmania_pkg::*;
#(
    parameter int PERFECT_WIN  = DEF_PERFECT_WIN,
    parameter int GOOD_WIN     = DEF_GOOD_WIN,
    parameter int OK_WIN       = DEF_OK_WIN,
    parameter int PTS_PERFECT  = DEF_PTS_PERFECT,
    parameter int PTS_GOOD     = DEF_PTS_GOOD,
    parameter int PTS_OK       = DEF_PTS_OK,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        key,
    input  logic        frame_rise,
    input  logic        arrow_valid,
    input  logic [9:0]  arrow_dist,
    input  logic        arrow_expired,
`ifdef HIT_JUDGE_COMBO_EN
    input  logic        bonus,
    output logic        hit_ev,
    output logic        miss_ev,
`endif
    output logic        consume,
    output logic [3:0]  hit,
    output logic [3:0]  miss,
    output logic [1:0]  grade,
    output lane_state_t state
);

    localparam int          CNT_W         = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] L_LOCK_LOAD = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [8:0]  L_PERFECT_WIN = 9'(PERFECT_WIN);
    localparam logic [8:0]  L_GOOD_WIN    = 9'(GOOD_WIN);
    localparam logic [8:0]  L_OK_WIN      = 9'(OK_WIN);
    localparam logic [2:0]  L_PTS_PERFECT = 3'(PTS_PERFECT);
    localparam logic [2:0]  L_PTS_GOOD    = 3'(PTS_GOOD);
    localparam logic [2:0]  L_PTS_OK      = 3'(PTS_OK);

    logic              r_key_s1, r_key_s2, r_key_prev;
    logic [2:0]        r_prime;
    lane_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_hit_acc, r_miss_acc, r_hit, r_miss;
    grade_t            r_grade;
    logic              r_consume;

    logic              w_key_rise, w_judge, w_hit_judged;
    logic [9:0]        w_neg;
    logic [8:0]        w_abs;
    logic [2:0]        w_hit_pts, w_bonus_pts;
    logic [1:0]        w_miss_pts;
    grade_t            w_grade;

    // Edges are only trusted once the synchronizer and prev flop hold real key
    // samples, so a key held through reset never looks like a fresh press.
    assign w_key_rise = r_key_s2 & ~r_key_prev & r_prime[2];
    assign w_judge    = (r_state == S_IDLE) & w_key_rise;

    assign w_neg = 10'd0 - arrow_dist;
    assign w_abs = !arrow_dist[9]          ? arrow_dist[8:0] :
                   (arrow_dist == 10'h200) ? 9'd511          : w_neg[8:0];

`ifdef HIT_JUDGE_COMBO_EN
    assign w_bonus_pts = {2'b00, bonus};
    assign hit_ev      = w_hit_judged;
    assign miss_ev     = (w_miss_pts != 2'd0);
`else
    assign w_bonus_pts = 3'd0;
`endif

    always_comb begin
        w_hit_pts    = 3'd0;
        w_miss_pts   = 2'd0;
        w_grade      = G_NONE;
        w_hit_judged = 1'b0;
        if (w_judge) begin
            if (arrow_valid && (w_abs <= L_PERFECT_WIN)) begin
                w_hit_pts    = L_PTS_PERFECT + w_bonus_pts;
                w_grade      = G_PERFECT;
                w_hit_judged = 1'b1;
            end else if (arrow_valid && (w_abs <= L_GOOD_WIN)) begin
                w_hit_pts    = L_PTS_GOOD;
                w_grade      = G_GOOD;
                w_hit_judged = 1'b1;
            end else if (arrow_valid && (w_abs <= L_OK_WIN)) begin
                w_hit_pts    = L_PTS_OK;
                w_grade      = G_OK;
                w_hit_judged = 1'b1;
            end else begin
                w_miss_pts   = 2'd1;
            end
        end
        if (arrow_expired) begin
            w_miss_pts = w_miss_pts + 2'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_key_s1   <= 1'b0;
            r_key_s2   <= 1'b0;
            r_key_prev <= 1'b0;
            r_prime    <= 3'b000;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hit_acc  <= 4'd0;
            r_miss_acc <= 4'd0;
            r_hit      <= 4'd0;
            r_miss     <= 4'd0;
            r_grade    <= G_NONE;
            r_consume  <= 1'b0;
        end else begin
            r_key_s1   <= key;
            r_key_s2   <= r_key_s1;
            r_key_prev <= r_key_s2;
            r_prime    <= {r_prime[1:0], 1'b1};

            case (r_state)
                S_IDLE: begin
                    if (w_key_rise) r_state <= S_HELD;
                end
                S_HELD: begin
                    if (!r_key_s2) begin
                        r_state <= S_LOCKOUT;
                        r_cnt   <= L_LOCK_LOAD;
                    end
                end
                S_LOCKOUT: begin
                    if (r_cnt == '0) r_state <= S_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase

            r_consume <= w_hit_judged;
            if (w_judge)            r_grade <= w_grade;
            else if (arrow_expired) r_grade <= G_NONE;

            // At a frame edge the finished totals move out and this cycle's
            // events seed the new frame, so nothing is dropped or counted twice.
            if (frame_rise) begin
                r_hit      <= r_hit_acc;
                r_miss     <= r_miss_acc;
                r_hit_acc  <= sat_add4(4'd0, w_hit_pts);
                r_miss_acc <= sat_add4(4'd0, {1'b0, w_miss_pts});
            end else begin
                r_hit_acc  <= sat_add4(r_hit_acc, w_hit_pts);
                r_miss_acc <= sat_add4(r_miss_acc, {1'b0, w_miss_pts});
            end
        end
    end

    assign consume = r_consume;
    assign hit     = r_hit;
    assign miss    = r_miss;
    assign grade   = r_grade;
    assign state   = r_state;

endmodule

// File: rtl/hit_judge.sv
// Four-lane hit judge: frame strobe conditioning, lane instances and, with
// HIT_JUDGE_COMBO_EN defined, the cross-lane combo counter and PERFECT bonus.
module hit_judge
    import stepmania_pkg::*;
#(
    parameter int PERFECT_WIN  = DEF_PERFECT_WIN,
    parameter int GOOD_WIN     = DEF_GOOD_WIN,
    parameter int OK_WIN       = DEF_OK_WIN,
    parameter int PTS_PERFECT  = DEF_PTS_PERFECT,
    parameter int PTS_GOOD     = DEF_PTS_GOOD,
    parameter int PTS_OK       = DEF_PTS_OK,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic                               Clk,
    input  logic                               reset,
    input  logic                               frame_clk,
    input  logic [NUM_LANES-1:0]               key,
    input  logic [NUM_LANES-1:0]               arrow_valid,
    input  logic signed [9:0]                  arrow_dist0,
    input  logic signed [9:0]                  arrow_dist1,
    input  logic signed [9:0]                  arrow_dist2,
    input  logic signed [9:0]                  arrow_dist3,
    input  logic [NUM_LANES-1:0]               arrow_expired,
    output logic [NUM_LANES-1:0]               arrow_consume,
    output logic [3:0]                         hit0,
    output logic [3:0]                         hit1,
    output logic [3:0]                         hit2,
    output logic [3:0]                         hit3,
    output logic [3:0]                         miss0,
    output logic [3:0]                         miss1,
    output logic [3:0]                         miss2,
    output logic [3:0]                         miss3,
    output logic [1:0]                         grade0,
    output logic [1:0]                         grade1,
    output logic [1:0]                         grade2,
    output logic [1:0]                         grade3,
`ifdef HIT_JUDGE_COMBO_EN
    output logic [9:0]                         combo,
`endif
    output lane_state_t [NUM_LANES-1:0]        dbg_lane_state
);

    logic       r_frame_s1, r_frame_s2, r_frame_prev;
    logic       w_frame_rise;
    logic [9:0] w_dist  [NUM_LANES];
    logic [3:0] w_hit   [NUM_LANES];
    logic [3:0] w_miss  [NUM_LANES];
    logic [1:0] w_grade [NUM_LANES];

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_frame_s1   <= 1'b0;
            r_frame_s2   <= 1'b0;
            r_frame_prev <= 1'b0;
        end else begin
            r_frame_s1   <= frame_clk;
            r_frame_s2   <= r_frame_s1;
            r_frame_prev <= r_frame_s2;
        end
    end

    assign w_frame_rise = r_frame_s2 & ~r_frame_prev;

    assign w_dist[0] = arrow_dist0;
    assign w_dist[1] = arrow_dist1;
    assign w_dist[2] = arrow_dist2;
    assign w_dist[3] = arrow_dist3;

`ifdef HIT_JUDGE_COMBO_EN
    logic [NUM_LANES-1:0] w_hit_ev, w_miss_ev;
    logic [9:0]           r_combo;
    logic [2:0]           w_nhits;
    logic [10:0]          w_combo_sum;
    logic                 w_bonus;

    always_comb begin
        w_nhits = 3'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_nhits = w_nhits + {2'b00, w_hit_ev[i]};
        end
    end

    assign w_combo_sum = {1'b0, r_combo} + {8'd0, w_nhits};
    assign w_bonus     = (r_combo >= 10'(COMBO_BONUS_AT));

    // Any miss in the cycle wins over hits landing alongside it.
    always_ff @(posedge Clk) begin
        if (reset)                           r_combo <= 10'd0;
        else if (|w_miss_ev)                 r_combo <= 10'd0;
        else if (w_combo_sum > 11'(COMBO_MAX)) r_combo <= 10'(COMBO_MAX);
        else                                 r_combo <= w_combo_sum[9:0];
    end

    assign combo = r_combo;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_judge #(
            .PERFECT_WIN (PERFECT_WIN),
            .GOOD_WIN    (GOOD_WIN),
            .OK_WIN      (OK_WIN),
            .PTS_PERFECT (PTS_PERFECT),
            .PTS_GOOD    (PTS_GOOD),
            .PTS_OK      (PTS_OK),
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_lane (
            .Clk          (Clk),
            .reset        (reset),
            .key          (key[g]),
            .frame_rise   (w_frame_rise),
            .arrow_valid  (arrow_valid[g]),
            .arrow_dist   (w_dist[g]),
            .arrow_expired(arrow_expired[g]),
`ifdef HIT_JUDGE_COMBO_EN
            .bonus        (w_bonus),
            .hit_ev       (w_hit_ev[g]),
            .miss_ev      (w_miss_ev[g]),
`endif
            .consume      (arrow_consume[g]),
            .hit          (w_hit[g]),
            .miss         (w_miss[g]),
            .grade        (w_grade[g]),
            .state        (dbg_lane_state[g])
        );
    end

    assign hit0   = w_hit[0];
    assign hit1   = w_hit[1];
    assign hit2   = w_hit[2];
    assign hit3   = w_hit[3];
    assign miss0  = w_miss[0];
    assign miss1  = w_miss[1];
    assign miss2  = w_miss[2];
    assign miss3  = w_miss[3];
    assign grade0 = w_grade[0];
    assign grade1 = w_grade[1];
    assign grade2 = w_grade[2];
    assign grade3 = w_grade[3];

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: directed presses/expires/frames push
// hand-computed expectations; monitors compare frame outputs and consume pulses.
module tb_hit_judge;
    import stepmania_pkg::*;

    logic              Clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_clk = 1'b0;
    logic [3:0]        key = 4'd0;
    logic [3:0]        arrow_valid = 4'd0;
    logic [3:0]        arrow_expired = 4'd0;
    logic signed [9:0] dist0 = '0, dist1 = '0, dist2 = '0, dist3 = '0;
    logic [3:0]        arrow_consume;
    logic [3:0]        hit0, hit1, hit2, hit3, miss0, miss1, miss2, miss3;
    logic [1:0]        grade0, grade1, grade2, grade3;
    lane_state_t [3:0] dbg_state;
`ifdef HIT_JUDGE_COMBO_EN
    logic [9:0]        combo;
`endif

    hit_judge #(.DEBOUNCE_CYC(50)) dut (
        .Clk           (Clk),
        .reset         (reset),
        .frame_clk     (frame_clk),
        .key           (key),
        .arrow_valid   (arrow_valid),
        .arrow_dist0   (dist0),
        .arrow_dist1   (dist1),
        .arrow_dist2   (dist2),
        .arrow_dist3   (dist3),
        .arrow_expired (arrow_expired),
        .arrow_consume (arrow_consume),
        .hit0(hit0), .hit1(hit1), .hit2(hit2), .hit3(hit3),
        .miss0(miss0), .miss1(miss1), .miss2(miss2), .miss3(miss3),
        .grade0(grade0), .grade1(grade1), .grade2(grade2), .grade3(grade3),
`ifdef HIT_JUDGE_COMBO_EN
        .combo         (combo),
`endif
        .dbg_lane_state(dbg_state)
    );

    // clock / reset
    always #5 Clk = ~Clk;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // scoreboard
    int          total = 0;
    int          bad = 0;
    logic [39:0] exp_q[$];
    logic [35:0] cons_q[$];
    logic [39:0] last_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] dut_frame();
        return {hit3, hit2, hit1, hit0, miss3, miss2, miss1, miss0, grade3, grade2, grade1, grade0};
    endfunction

    // frame monitor: hold check just before the update, value check just after
    initial begin : frame_mon
        logic [39:0] e;
        forever begin
            @(posedge frame_clk);
            repeat (2) @(posedge Clk);
            @(negedge Clk);
            check("frame_hold", {32'd0, dut_frame() >> 8}, {32'd0, last_exp >> 8});
            @(negedge Clk);
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame_out", {24'd0, dut_frame()}, {24'd0, e});
                last_exp = e;
            end
        end
    end

    // consume monitor
    always @(negedge Clk) begin
        if (arrow_consume != 4'd0) begin
            if (cons_q.size() == 0) check("consume_unexpected", {60'd0, arrow_consume}, 64'd0);
            else check("consume", {28'd0, 32'(cyc), arrow_consume}, {28'd0, cons_q.pop_front()});
        end
    end

    // drivers
    task automatic press(input int lane, input int hold, input bit hit);
        @(negedge Clk);
        key[lane] = 1'b1;
        if (hit) cons_q.push_back({32'(cyc + 3), 4'(1 << lane)});
        repeat (hold) @(negedge Clk);
        key[lane] = 1'b0;
        repeat (60) @(negedge Clk);
    endtask

    task automatic expire(input int lane);
        @(negedge Clk);
        arrow_expired[lane] = 1'b1;
        @(negedge Clk);
        arrow_expired[lane] = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic frame(input logic [15:0] h, input logic [15:0] m, input logic [7:0] g,
                         input int exp_lane);
        exp_q.push_back({h, m, g});
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        if (exp_lane >= 0) arrow_expired[exp_lane] = 1'b1;
        @(negedge Clk);
        arrow_expired = 4'd0;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        reset = 1'b1;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        last_exp = '0;
        repeat (5) @(negedge Clk);
    endtask

    initial begin
        repeat (4) @(negedge Clk);
        reset = 1'b0;
        repeat (5) @(negedge Clk);
        check("reset_outputs", {20'd0, arrow_consume, dut_frame()}, 64'd0);
        check("reset_state", {56'd0, dbg_state}, 64'd0);
        frame(16'h0000, 16'h0000, 8'h00, -1);

        // single PERFECT in lane 0
        arrow_valid[0] = 1'b1; dist0 = 10'sd3;
        press(0, 10, 1);
        frame(16'h0003, 16'h0000, 8'h03, -1);

        // window edges and abs(-512)
        dist0 = -10'sd10; press(0, 10, 1);
        dist0 = 10'sd20;  press(0, 10, 1);
        dist0 = 10'sd21;  press(0, 10, 0);
        arrow_valid[1] = 1'b1; dist1 = -10'sd512; press(1, 10, 0);
        arrow_valid[2] = 1'b1; dist2 = -10'sd4;   press(2, 10, 1);
        dist2 = 10'sd5; press(2, 10, 1);
        frame(16'h0503, 16'h0011, 8'h20, -1);

        // bouncing key on lane 1: only the first edge is judged
        dist1 = 10'sd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            key[1] = 1'b1;
            if (i == 0) cons_q.push_back({32'(cyc + 3), 4'b0010});
            repeat (4) @(negedge Clk);
            key[1] = 1'b0;
            repeat (3) @(negedge Clk);
        end
        repeat (70) @(negedge Clk);
        frame(16'h0030, 16'h0000, 8'h2C, -1);

        // expire coincident with the frame edge lands in the next frame
        expire(2);
        expire(2);
        frame(16'h0000, 16'h0200, 8'h0C, 2);
        frame(16'h0000, 16'h0100, 8'h0C, -1);
        frame(16'h0000, 16'h0000, 8'h0C, -1);

        // saturation: 6 PERFECTs = 18 points clamps to 15
        arrow_valid[3] = 1'b1; dist3 = -10'sd1;
        for (int i = 0; i < 6; i++) press(3, 10, 1);
        frame(16'hF000, 16'h0000, 8'hCC, -1);

        // reset mid-frame discards pending hits
        dist0 = 10'sd0;
        press(0, 10, 1);
        press(0, 10, 1);
        do_reset();
        frame(16'h0000, 16'h0000, 8'h00, -1);

`ifdef HIT_JUDGE_COMBO_EN
        arrow_valid = 4'hF; dist0 = '0; dist1 = '0; dist2 = '0; dist3 = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            key[k % 4] = 1'b1;
            cons_q.push_back({32'(cyc + 3), 4'(1 << (k % 4))});
            repeat (5) @(negedge Clk);
            key[k % 4] = 1'b0;
            repeat (15) @(negedge Clk);
        end
        repeat (15) @(negedge Clk);
        check("combo_50", {54'd0, combo}, 64'd50);
        frame(16'hFFFF, 16'h0000, 8'hFF, -1);
        press(0, 10, 1);
        check("combo_51", {54'd0, combo}, 64'd51);
        frame(16'h0004, 16'h0000, 8'hFF, -1);
        expire(1);
        check("combo_clear", {54'd0, combo}, 64'd0);
        frame(16'h0000, 16'h0010, 8'hF3, -1);
`endif

        repeat (20) @(negedge Clk);
        check("frames_pending", 64'(exp_q.size()), 64'd0);
        check("consumes_pending", 64'(cons_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
